// File: rtl/music_pkg.sv
// Shared definitions for the buzzer player: note word layout, sequencer
// states and the tempo scaling helper.
package music_pkg;

   localparam int DUR_MSB  = 15;
   localparam int DUR_LSB  = 13;
   localparam int FREQ_MSB = 9;
   localparam int FREQ_LSB = 0;
   localparam int FREQ_W   = 10;

   localparam logic [FREQ_W-1:0] END_MARK  = 10'h3FF;
   localparam logic [FREQ_W-1:0] REST_FREQ = 10'h000;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_WAIT   = 3'd2,
      ST_DECODE = 3'd3,
      ST_DIV    = 3'd4,
      ST_PLAY   = 3'd5,
      ST_DONE   = 3'd6
   } seq_state_t;

   // Clock cycles per duration unit.
   function automatic longint unsigned rang_temp(input longint unsigned clk_ref,
                                                 input longint unsigned size,
                                                 input longint unsigned temp);
      return (clk_ref * size) / temp;
   endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider: DIVIDEND / divisor, one quotient bit per cycle,
// done pulses one cycle after the last iteration.
module seq_divider #(
   parameter int unsigned DIVIDEND = 32'd50_000_000,
   parameter int          QW       = 32'd26,
   parameter int          DVW      = 32'd11
) (
   input  logic           clk,
   input  logic           reset_l,
   input  logic           start,
   input  logic           abort,
   input  logic [DVW-1:0] divisor,
   output logic           done,
   output logic [QW-1:0]  quotient
);

   localparam int CW = $clog2(QW + 1);

   logic [QW-1:0]  quo_r;
   logic [DVW-1:0] rem_r;
   logic [DVW-1:0] dvs_r;
   logic [CW-1:0]  cnt_r;
   logic           busy_r;
   logic           done_r;
   logic [DVW:0]   shift_s;
   logic [DVW:0]   diff_s;

   // Trial subtraction; a set MSB on diff_s means the divisor did not fit.
   always_comb begin
      shift_s = {rem_r, quo_r[QW-1]};
      diff_s  = shift_s - {1'b0, dvs_r};
   end

   // Load on start, drop everything on abort, otherwise iterate while busy.
   always_ff @(posedge clk or posedge reset_l) begin
      if (reset_l) begin
         quo_r  <= {QW{1'b0}};
         rem_r  <= {DVW{1'b0}};
         dvs_r  <= {DVW{1'b0}};
         cnt_r  <= {CW{1'b0}};
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else if (start) begin
         quo_r  <= QW'(DIVIDEND);
         rem_r  <= {DVW{1'b0}};
         dvs_r  <= divisor;
         cnt_r  <= CW'(QW);
         busy_r <= 1'b1;
         done_r <= 1'b0;
      end else if (abort) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else if (busy_r) begin
         if (!diff_s[DVW]) begin
            rem_r <= diff_s[DVW-1:0];
            quo_r <= {quo_r[QW-2:0], 1'b1};
         end else begin
            rem_r <= shift_s[DVW-1:0];
            quo_r <= {quo_r[QW-2:0], 1'b0};
         end
         cnt_r <= cnt_r - CW'(1'b1);
         if (cnt_r == CW'(1'b1)) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
         end
      end else begin
         done_r <= 1'b0;
      end
   end

   assign done     = done_r;
   assign quotient = quo_r;

endmodule

// File: rtl/note_play_sequencer.sv
// Note RAM playback controller: arbitrates the RAM port with the loader,
// fetches note words in order and drives the buzzer for each note.
module note_play_sequencer
   import music_pkg::*;
#(
   parameter int unsigned CLK_REF  = 32'd50_000_000,
   parameter int unsigned SIZE     = 32'd4,
   parameter int unsigned TEMP     = 32'd8,
   parameter int unsigned NOTE_MIN = 32'd21,
   parameter int unsigned NOTE_MAX = 32'd520,
   parameter int          ADDR_W   = 32'd8
) (
   input  logic              clk,
   input  logic              reset_l,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [15:0]       wr_data,
   output logic              wr_gnt,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   input  logic [15:0]       mem_rdata,
   input  logic              start,
   input  logic              stop,
   output logic              work,
   output logic              complit,
   output logic              buzzer_o,
   output logic              bad_note
);

   localparam longint unsigned RANG_TEMP = rang_temp(CLK_REF, SIZE, TEMP);
   localparam int              DUR_W     = $clog2(RANG_TEMP * 64'd8);
   localparam int              QW        = $clog2(CLK_REF);
   localparam logic [DUR_W-1:0]  RT_L      = DUR_W'(RANG_TEMP);
   localparam logic [FREQ_W-1:0] FMIN      = FREQ_W'(NOTE_MIN);
   localparam logic [FREQ_W-1:0] FMAX      = FREQ_W'(NOTE_MAX);
   localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

   seq_state_t        state_r, state_nx_s;
   logic [ADDR_W-1:0] addr_r;
   logic [DUR_W-1:0]  dur_cnt_r, dur_load_s;
   logic [QW-1:0]     hp_r, hp_cnt_r, quo_s, hp_new_s;
   logic              tone_en_r, buzzer_r, bad_note_r;
   logic [FREQ_W-1:0] freq_s;
   logic              end_s, bad_s, rest_s, dur_end_s, hp_end_s;
   logic              div_start_s, div_done_s, abort_s, gnt_s;
   logic              unused_s;

   // Field decode of the word currently on the read bus.
   always_comb begin
      freq_s     = mem_rdata[FREQ_MSB:FREQ_LSB];
      end_s      = (freq_s == END_MARK);
      bad_s      = !end_s && (freq_s != REST_FREQ) && ((freq_s < FMIN) || (freq_s > FMAX));
      rest_s     = (freq_s == REST_FREQ) || bad_s;
      dur_load_s = (DUR_W'(mem_rdata[DUR_MSB:DUR_LSB]) + DUR_W'(1'b1)) * RT_L - DUR_W'(1'b1);
      dur_end_s  = (dur_cnt_r == {DUR_W{1'b0}});
      hp_end_s   = (hp_cnt_r == {QW{1'b0}});
      hp_new_s   = (quo_s == {QW{1'b0}}) ? QW'(1'b1) : quo_s;
      abort_s    = (state_r != ST_DIV);
      gnt_s      = (state_r == ST_IDLE) && wr_req && !start && !reset_l;
   end

   // Next-state logic; stop pulls any active state straight back to IDLE.
   always_comb begin
      state_nx_s  = state_r;
      div_start_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) state_nx_s = ST_FETCH;
            else       state_nx_s = ST_IDLE;
         end
         ST_FETCH: begin
            if (stop) state_nx_s = ST_IDLE;
            else      state_nx_s = ST_WAIT;
         end
         ST_WAIT: begin
            if (stop) state_nx_s = ST_IDLE;
            else      state_nx_s = ST_DECODE;
         end
         ST_DECODE: begin
            if (stop)        state_nx_s = ST_IDLE;
            else if (end_s)  state_nx_s = ST_DONE;
            else if (rest_s) state_nx_s = ST_PLAY;
            else begin
               state_nx_s  = ST_DIV;
               div_start_s = 1'b1;
            end
         end
         ST_DIV: begin
            if (stop)            state_nx_s = ST_IDLE;
            else if (div_done_s) state_nx_s = ST_PLAY;
            else                 state_nx_s = ST_DIV;
         end
         ST_PLAY: begin
            if (stop)                     state_nx_s = ST_IDLE;
            else if (!dur_end_s)          state_nx_s = ST_PLAY;
            else if (addr_r == ADDR_LAST) state_nx_s = ST_DONE;
            else                          state_nx_s = ST_FETCH;
         end
         ST_DONE:  state_nx_s = ST_IDLE;
         default:  state_nx_s = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset_l) begin
      if (reset_l) state_r <= ST_IDLE;
      else         state_r <= state_nx_s;
   end

   // Address, duration, half-period and buzzer datapath.
   always_ff @(posedge clk or posedge reset_l) begin
      if (reset_l) begin
         addr_r     <= {ADDR_W{1'b0}};
         dur_cnt_r  <= {DUR_W{1'b0}};
         hp_r       <= {QW{1'b0}};
         hp_cnt_r   <= {QW{1'b0}};
         tone_en_r  <= 1'b0;
         buzzer_r   <= 1'b0;
         bad_note_r <= 1'b0;
      end else begin
         if (state_nx_s == ST_IDLE)
            addr_r <= {ADDR_W{1'b0}};
         else if ((state_r == ST_PLAY) && (state_nx_s == ST_FETCH))
            addr_r <= addr_r + ADDR_W'(1'b1);

         if (state_r == ST_DECODE) begin
            dur_cnt_r <= dur_load_s;
            tone_en_r <= !rest_s && !end_s;
         end else if ((state_r == ST_PLAY) && !dur_end_s) begin
            dur_cnt_r <= dur_cnt_r - DUR_W'(1'b1);
         end

         if ((state_r == ST_DIV) && div_done_s) begin
            hp_r     <= hp_new_s;
            hp_cnt_r <= hp_new_s - QW'(1'b1);
         end else if (state_r == ST_PLAY) begin
            hp_cnt_r <= hp_end_s ? (hp_r - QW'(1'b1)) : (hp_cnt_r - QW'(1'b1));
         end

         // Silent outside PLAY; the first PLAY cycle is always low.
         if (state_nx_s != ST_PLAY)
            buzzer_r <= 1'b0;
         else if ((state_r == ST_PLAY) && tone_en_r && hp_end_s)
            buzzer_r <= ~buzzer_r;

         if ((state_r == ST_IDLE) && start)
            bad_note_r <= 1'b0;
         else if ((state_r == ST_DECODE) && !stop && bad_s)
            bad_note_r <= 1'b1;
      end
   end

   seq_divider #(
      .DIVIDEND (CLK_REF),
      .QW       (QW),
      .DVW      (FREQ_W + 1)
   ) u_div (
      .clk      (clk),
      .reset_l  (reset_l),
      .start    (div_start_s),
      .abort    (abort_s),
      .divisor  ({freq_s, 1'b0}),
      .done     (div_done_s),
      .quotient (quo_s)
   );

   assign unused_s  = ^mem_rdata[12:10];
   assign wr_gnt    = gnt_s;
   assign mem_we    = gnt_s;
   assign mem_addr  = gnt_s ? wr_addr : addr_r;
   assign mem_wdata = gnt_s ? wr_data : 16'h0000;
   assign work      = (state_r != ST_IDLE);
   assign complit   = (state_r == ST_DONE);
   assign buzzer_o  = buzzer_r;
   assign bad_note  = bad_note_r;

endmodule

// File: doc/note_play_sequencer.md
# note_play_sequencer

Playback controller for the note RAM of the buzzer player. It shares the single memory port between the UART loader (writes) and playback (reads), fetches note words in address order, and converts each frequency to a tone half-period with a sequential divider. It holds each note for its tempo-scaled duration while driving the buzzer, and sits between the UART receive path, the note RAM and `buzzer_o`.

## Interface
- `CLK_REF`, 50_000_000: clock frequency, Hz
- `SIZE`, 4: bar size in tempo units
- `TEMP`, 8: tempo divisor; `RANG_TEMP = CLK_REF*SIZE/TEMP` cycles per duration unit
- `NOTE_MIN`, 21: lowest legal frequency, Hz
- `NOTE_MAX`, 520: highest legal frequency, Hz
- `ADDR_W`, 8: note RAM address width
- `clk`  in  1  single clock, rising edge
- `reset_l`  in  1  asynchronous, active-high reset
- `wr_req`  in  1  loader write request, held until granted
- `wr_addr`  in  ADDR_W  loader write address
- `wr_data`  in  16  loader write word
- `wr_gnt`  out  1  one-cycle grant; the write is issued to memory in the same cycle
- `mem_we`  out  1  RAM write enable
- `mem_addr`  out  ADDR_W  RAM address
- `mem_wdata`  out  16  RAM write data
- `mem_rdata`  in  16  RAM read data, valid one cycle after the address
- `start`  in  1  pulse; begin playback at address 0
- `stop`  in  1  pulse; abort playback
- `work`  out  1  high while not IDLE
- `complit`  out  1  one-cycle pulse at normal song end
- `buzzer_o`  out  1  tone output
- `bad_note`  out  1  sticky; set when an out-of-range frequency is encountered, cleared on `start`

## Operation
- Note word fields:
  - [15:13] `dur`: the note lasts (dur+1)*RANG_TEMP cycles.
  - [12:10] reserved, ignored.
  - [9:0] `freq` in Hz. 0 = rest; 10'h3FF = end marker.
- `freq` outside NOTE_MIN..NOTE_MAX, other than 0 or 3FF: played as a rest of the same duration, and `bad_note` is set.
- Half-period = floor(CLK_REF/(2*freq)), clamped to a minimum of 1.
- States:
  - IDLE: grants writes.
  - FETCH: drives `mem_addr` = addr, `mem_we` = 0.
  - WAIT: read latency.
  - DECODE: latches the word. End marker → DONE; rest or bad note → PLAY; otherwise → DIV.
  - DIV: divider busy until done, then → PLAY.
  - PLAY: counts the duration; at expiry, addr+1 → FETCH. If addr = 2^ADDR_W−1, → DONE instead (no wrap).
  - DONE: pulses `complit`, addr := 0, → IDLE.
- Arbitration:
  - Writes are granted only in IDLE.
  - `start` and `wr_req` in the same IDLE cycle: `start` wins; the write waits until the next IDLE.
  - Outside IDLE, `wr_gnt` = 0 and `mem_we` = 0.
- `stop` in any non-IDLE state: → IDLE next cycle, `buzzer_o` = 0, addr := 0, no `complit`. Any divider in flight is abandoned.
- `start` while not IDLE: ignored.

## Timing
- Reset values: all outputs 0; state IDLE; addr 0.
- Write path: `wr_req` high in IDLE at cycle t → `wr_gnt`, `mem_we`, `mem_addr` = `wr_addr` and `mem_wdata` all at cycle t (combinational grant). `wr_gnt` is never asserted twice for one request.
- Read path: `start` at t → FETCH t+1 → WAIT t+2 → DECODE t+3.
- DIV lasts exactly `$clog2(CLK_REF)+1` cycles.
- PLAY lasts exactly (dur+1)*RANG_TEMP cycles.
  - `buzzer_o` is 0 on the first PLAY cycle and toggles every half-period cycles.
  - `buzzer_o` is forced to 0 on leaving PLAY.
  - For a rest, `buzzer_o` stays 0 throughout.
- Note-to-note gap: 3 cycles (FETCH, WAIT, DECODE) plus DIV when applicable. `buzzer_o` = 0 during the gap.
- `complit` is high for exactly one cycle, in DONE. `work` falls in the following cycle.

## Structure
- Package `music_pkg`: field bit positions, `END_MARK` = 10'h3FF, state enum `seq_state_t`, `RANG_TEMP` function.
- Sub-module `seq_divider`: restoring divider with `start`/`done` handshake, dividend CLK_REF, divisor 2*freq, quotient width `$clog2(CLK_REF)`.

## Test plan
All scenarios use CLK_REF=1000, SIZE=4, TEMP=8 (RANG_TEMP=500), ADDR_W=4.
- Load and play one note: write addr0=16'h0064 and addr1=16'h03FF, then `start` → `buzzer_o` toggles every 5 cycles for 500 cycles; `complit` pulses once; `work` falls.
- Rest and duration: addr0=16'h2000 (dur 1, rest), addr1=3FF → `buzzer_o` stays 0 for 1000 cycles, then `complit`.
- Bad note: addr0=16'h0005 → rest of 500 cycles; `bad_note` = 1 until the next `start`.
- Arbitration: `wr_req` held during playback → `wr_gnt` = 0 until IDLE. `start` and `wr_req` in the same cycle → playback begins and the write is deferred.
- Stop mid-note: `stop` 100 cycles into PLAY of freq 250 → IDLE next cycle, `buzzer_o` = 0, no `complit`. A following `start` replays from address 0.
- Reset mid-DIV: assert `reset_l` during DIV → all outputs 0 immediately; addr 0; no divider result is applied afterwards.
